// File: rtl/uart_frame_tx.sv
// uart_frame_tx: LSB-first UART transmitter, 8N1 by default or 8E1 when UART_PARITY_EN is defined.
// A one-byte holding register lets the next byte arrive mid-frame so frames stream back-to-back.
`timescale 1ns/1ps
module uart_frame_tx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_out,
    output logic       o_busy
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic [7:0]    hold_reg, hold_next;
    logic          hold_full_reg, hold_full_next;
    logic          out_reg, busy_reg, ready_reg;
    logic          line_next;
    logic          accept, tick, load_direct;

    assign accept = i_valid && ready_reg;
    assign tick   = (cnt_reg == CNT_LAST);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg + CW'(1);
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        load_direct    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                cnt_next     = '0;
                bit_idx_next = '0;
                if (accept && !hold_full_reg) begin
                    load_direct = 1'b1;
                end
            end
            S_START: begin
                if (tick) begin
                    state_next   = S_DATA;
                    cnt_next     = '0;
                    bit_idx_next = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_next = '0;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    state_next = S_STOP;
                    cnt_next   = '0;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    cnt_next = '0;
                    if (hold_full_reg) begin
                        shift_next     = hold_reg;
                        hold_full_next = 1'b0;
                        state_next     = S_START;
                    end else if (accept) begin
                        load_direct = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase

        // A handshake either starts a frame straight away or parks the byte in hold.
        if (load_direct) begin
            shift_next   = i_data;
            state_next   = S_START;
            cnt_next     = '0;
            bit_idx_next = '0;
        end else if (accept) begin
            hold_next      = i_data;
            hold_full_next = 1'b1;
        end
    end

    // Line level follows the current state, so the start bit appears one cycle after acceptance.
    always_comb begin
        line_next = 1'b1;
        case (state_reg)
            S_START:  line_next = 1'b0;
            S_DATA:   line_next = shift_reg[bit_idx_reg];
`ifdef UART_PARITY_EN
            S_PARITY: line_next = ^shift_reg;
`endif
            default:  line_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            out_reg       <= 1'b1;
            busy_reg      <= 1'b0;
            ready_reg     <= 1'b1;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            out_reg       <= line_next;
            busy_reg      <= (state_reg != S_IDLE);
            // Drops with hold filling; rises one cycle after hold drains, as the start bit appears.
            ready_reg     <= !hold_full_next && !hold_full_reg;
        end
    end

    assign o_out   = out_reg;
    assign o_busy  = busy_reg;
    assign o_ready = ready_reg;

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: randomized bench for uart_frame_tx, checked against a frame-timing model
// built from handshake times (start = max(accept+1, previous start + frame length)).
`timescale 1ns/1ps
module tb_uart_frame_tx;
    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int DIV      = CLK_FREQ / BAUD;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV;
    localparam int MAXC  = 32768;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_valid = 1'b0;
    logic       o_ready, o_out, o_busy;

    uart_frame_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_out   (o_out),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit line_log [MAXC];
    bit busy_log [MAXC];
    bit rdy_log  [MAXC];
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            line_log[cyc] = o_out;
            busy_log[cyc] = o_busy;
            rdy_log[cyc]  = o_ready;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    int         hs_cyc[$];
    logic [7:0] hs_byte[$];
    int         st_q[$];

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic build_model();
        int s;
        st_q.delete();
        for (int i = 0; i < hs_cyc.size(); i++) begin
            s = hs_cyc[i] + 1;
            if (i > 0 && st_q[i-1] + FRAME > s) s = st_q[i-1] + FRAME;
            st_q.push_back(s);
        end
    endtask

    // Presents bytes in order; while o_ready is low the data lines carry junk that must be ignored.
    task automatic send(input logic [7:0] bytes[$], input int idle_pct);
        int idx;
        int guard;
        int n;
        int limit;
        idx = 0;
        guard = 0;
        n = bytes.size();
        limit = (n + 2) * FRAME * 2;
        while (idx < n && guard < limit) begin
            @(negedge clk);
            guard++;
            if (i_valid && $urandom_range(0, 99) < idle_pct) i_valid = 1'b0;
            else if (!i_valid && $urandom_range(0, 99) >= idle_pct) i_valid = 1'b1;
            if (i_valid) begin
                if (o_ready) begin
                    i_data = bytes[idx];
                    hs_cyc.push_back(cyc + 1);
                    hs_byte.push_back(bytes[idx]);
                    idx++;
                end else begin
                    i_data = 8'($urandom);
                end
            end
        end
        if (idx < n) check("send_timeout", idx, n);
        @(negedge clk);
        i_valid = 1'b0;
        i_data  = 8'($urandom);
    endtask

    task automatic wait_drain();
        int tgt;
        build_model();
        tgt = (st_q.size() > 0) ? st_q[st_q.size()-1] + FRAME + 3 : cyc + 3;
        while (cyc < tgt) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic verify(input int c0, input int c1);
        logic el, eb, er;
        logic [7:0] dec;
        int s;
        build_model();
        for (int c = c0; c <= c1; c++) begin
            el = 1'b1;
            eb = 1'b0;
            er = 1'b1;
            for (int i = 0; i < st_q.size(); i++) begin
                if (c >= st_q[i] && c < st_q[i] + FRAME) begin
                    el = frame_bit(hs_byte[i], (c - st_q[i]) / DIV);
                    eb = 1'b1;
                end
                if (st_q[i] > hs_cyc[i] + 1 && c >= hs_cyc[i] && c < st_q[i]) er = 1'b0;
            end
            check($sformatf("line@%0d", c), line_log[c], el);
            check($sformatf("busy@%0d", c), busy_log[c], eb);
            check($sformatf("ready@%0d", c), rdy_log[c], er);
        end
        for (int i = 0; i < st_q.size(); i++) begin
            s = st_q[i];
            if (s >= c0 && s + FRAME - 1 <= c1) begin
                for (int b = 0; b < 8; b++) dec[b] = line_log[s + DIV * (b + 1) + DIV / 2];
                check($sformatf("byte#%0d", i), dec, hs_byte[i]);
`ifdef UART_PARITY_EN
                check($sformatf("parity#%0d", i), line_log[s + 9 * DIV + DIV / 2], ^hs_byte[i]);
`endif
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        int base, base2, n0, gn, pct;

        repeat (4) @(negedge clk);
        check("rst_out", o_out, 1);
        check("rst_ready", o_ready, 1);
        check("rst_busy", o_busy, 0);
        rst_n = 1'b1;
        base = cyc;
        @(negedge clk);
        check("post_rst_out", o_out, 1);

        // Single byte 0x41
        q = {8'h41};
        send(q, 0);
        wait_drain();
        n0 = hs_cyc[0];
        check("sb_pre", line_log[n0], 1);
        check("sb_start", line_log[n0 + 1], 0);
        check("sb_start_end", line_log[n0 + DIV], 0);
        check("sb_bit0", line_log[n0 + DIV + 1], 1);
        check("sb_busy_on", busy_log[n0 + 1], 1);
        check("sb_busy_last", busy_log[n0 + FRAME], 1);
        check("sb_busy_off", busy_log[n0 + FRAME + 1], 0);

        // Back-to-back with i_valid held high
        q = {8'h55, 8'hA3};
        send(q, 0);
        wait_drain();
        n0 = hs_cyc[1];
        check("b2b_last_stop", line_log[n0 + FRAME], 1);
        check("b2b_second_start", line_log[n0 + FRAME + 1], 0);
        check("b2b_ready_low", rdy_log[n0 + FRAME], 0);
        check("b2b_ready_up", rdy_log[n0 + FRAME + 1], 1);

        // Backpressure
        q = {8'h01, 8'h02, 8'h03};
        send(q, 0);
        wait_drain();

        // Parity bytes
        q = {8'h07};
        send(q, 0);
        wait_drain();
        n0 = hs_cyc[hs_cyc.size() - 1];
`ifdef UART_PARITY_EN
        check("par07_bit", line_log[n0 + 9 * DIV + 1], 1);
        check("par07_busy_off", busy_log[n0 + 111], 0);
`else
        check("np07_stop", line_log[n0 + 9 * DIV + 1], 1);
        check("np07_busy_off", busy_log[n0 + 101], 0);
`endif
        q = {8'h03};
        send(q, 0);
        wait_drain();
        n0 = hs_cyc[hs_cyc.size() - 1];
`ifdef UART_PARITY_EN
        check("par03_bit", line_log[n0 + 9 * DIV + 1], 0);
`else
        check("np03_stop", line_log[n0 + 9 * DIV + 1], 1);
`endif

        // Random groups with random valid gaps and idle spells
        for (int g = 0; g < 8; g++) begin
            gn  = $urandom_range(1, 5);
            pct = $urandom_range(0, 80);
            q.delete();
            for (int k = 0; k < gn; k++) q.push_back(8'($urandom));
            send(q, pct);
            repeat ($urandom_range(0, 2 * FRAME)) @(negedge clk);
        end
        wait_drain();
        verify(base + 1, cyc - 1);

        // Reset mid-frame with a byte held
        hs_cyc.delete();
        hs_byte.delete();
        q = {8'hF0, 8'h99};
        send(q, 0);
        n0 = hs_cyc[0];
        while (cyc < n0 + 1 + 4 * DIV + DIV / 2) @(negedge clk);
        check("pre_rst_line", o_out, 0);
        check("pre_rst_ready", o_ready, 0);
        check("pre_rst_busy", o_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out", o_out, 1);
        check("mid_rst_ready", o_ready, 1);
        check("mid_rst_busy", o_busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base2 = cyc;
        hs_cyc.delete();
        hs_byte.delete();
        repeat (3 * FRAME) @(negedge clk);
        q = {8'h3C};
        send(q, 30);
        wait_drain();
        verify(base2 + 1, cyc - 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
